freq_a_gate_counter: RTL and testbench
======================================

Name: freq_a_gate_counter

Overview:
- Downstream consumer of the gate strobe `cout_b` produced by the base-interval generator.
- Counts rising edges of the measured (asynchronous) input signal over each gate interval. One interval runs between consecutive rising edges of `cout_b`.
- At the end of each interval it latches the count as `freq_a`, with overflow and missed-read status.
- Presents the result to the Nios-side register reader through a valid/ack handshake.

Parameters:
- CNT_W, 32: width of the edge counter and of `freq_a`.
- SYNC_STAGES, 2: number of flip-flops in the `sig_in` synchronizer; legal range 2..4.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  measurement enable; low forces IDLE.
- sig_in  in  1  measured signal, asynchronous to clk.
- cout_b  in  1  gate from the base-interval generator, synchronous to clk; only its rising edge is used.
- rd_ack  in  1  one-cycle pulse from the reader; consumes the current result.
- freq_a  out  CNT_W  latched edge count of the last complete interval.
- freq_valid  out  1  `freq_a` holds an unread result.
- overflow  out  1  the latched interval saturated the counter.
- missed  out  1  sticky; a result was overwritten while unread.

Behaviour:
- Reset:
  - Reset is synchronous and active-high on clk.
  - The synchronizer chain, edge-detect registers, counter, `freq_a`, `freq_valid`, `overflow` and `missed` all go to 0.
  - The FSM goes to IDLE.
- Synchronizer:
  - `sig_in` passes through SYNC_STAGES flops; `s_prev` holds the previous synchronized value.
  - `sig_edge = s_sync & ~s_prev`.
  - A `sig_in` rising edge appears as `sig_edge` SYNC_STAGES+1 clk cycles later.
- Gate detect:
  - `cout_b_d` is registered.
  - `gate = cout_b & ~cout_b_d`, a one-cycle pulse.
  - The rising edge of `cout_b` at reset release counts as a gate.
- FSM states: IDLE, ARM, RUN.
- IDLE:
  - Counter is held at 0.
  - `en = 1` → ARM on the next cycle.
- ARM (discards the partial first interval):
  - Counter is held at 0.
  - `gate` → RUN, with the counter cleared.
- RUN:
  - The counter increments on each `sig_edge`.
  - On `gate`:
    - `freq_a <= cnt + sig_edge`, saturating. An edge in the gate cycle belongs to the closing interval.
    - `overflow <= ovf_int`, or 1 if the add saturates.
    - The counter restarts at 0 and `ovf_int` clears.
    - The FSM stays in RUN.
  - Latch latency: `freq_a` and `freq_valid` are visible the cycle after `gate`.
- Saturation:
  - The counter stops at 2^CNT_W−1; further edges are ignored and `ovf_int` is set.
  - There is no wrap-around.
- `en` low:
  - In any state, `en = 0` → IDLE next cycle; counter and `ovf_int` clear.
  - `freq_a`, `freq_valid`, `overflow` and `missed` are retained.
  - A `gate` in the same cycle as `en = 0` is ignored; no latch.
- Handshake:
  - A latch sets `freq_valid`.
  - `rd_ack` with `freq_valid = 1` clears `freq_valid` and `missed`.
  - `rd_ack` with `freq_valid = 0` has no effect.
  - Latch in the same cycle as `rd_ack`: the latch wins. `freq_valid` stays 1 with the new data, `missed` clears, and the old data counts as read.
  - Latch while `freq_valid = 1` and no `rd_ack`: the result is overwritten and `missed <= 1`.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Nominal count:
  - Stimulus: reset; `en = 1`; `cout_b` rising every 1000 clk; `sig_in` toggles every 20 clk (period 40).
  - First gate only arms.
  - Second gate → `freq_a = 25`, `freq_valid = 1`, `overflow = 0`, `missed = 0`.
  - `rd_ack` → `freq_valid = 0`.
- Edge in gate cycle:
  - Stimulus: align a synchronized `sig_edge` with `gate`, with 9 earlier edges in the interval.
  - Required: `freq_a = 10`; the next interval starts from 0.
- Saturation:
  - Stimulus: CNT_W = 4; 20 edges in one interval.
  - Required: `freq_a = 15`, `overflow = 1`.
  - Next interval with 3 edges → `freq_a = 3`, `overflow = 0`.
- Missed read:
  - Stimulus: two latches with no `rd_ack`.
  - Required: `freq_a` = second count, `freq_valid = 1`, `missed = 1`.
  - `rd_ack` → `freq_valid = 0`, `missed = 0`.
- Simultaneous `rd_ack` and latch:
  - Required: `freq_valid` stays 1, `freq_a` = new count, `missed = 0`.
- Enable drop and reset mid-interval:
  - Stimulus: drop `en` mid-RUN, then raise it again.
  - Required: outputs are retained; the first gate after re-enable only arms, and the following gate gives a correct count.
  - Stimulus: assert `reset` mid-interval.
  - Required: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/freq_a_gate_counter.sv
// Gated edge counter: counts synchronized rising edges of sig_in between
// consecutive cout_b rising edges and hands the result to a reader via valid/ack.
module freq_a_gate_counter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  input  logic             cout_b,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] freq_a,
  output logic             freq_valid,
  output logic             overflow,
  output logic             missed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic                   r_cout_b_d;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   r_ovf_int;
  logic                   w_ovf_next;
  logic                   w_latch;
  logic [CNT_W-1:0]       r_freq_a;
  logic                   r_freq_valid;
  logic                   r_overflow;
  logic                   r_missed;

  logic                   w_s_sync;
  logic                   w_sig_edge;
  logic                   w_gate;
  logic [CNT_W:0]         w_sum;
  logic                   w_sum_sat;
  logic [CNT_W-1:0]       w_latch_val;
  logic                   w_latch_ovf;

  assign w_s_sync   = r_sync[SYNC_STAGES-1];
  assign w_sig_edge = w_s_sync & ~r_s_prev;
  assign w_gate     = cout_b & ~r_cout_b_d;

  // An edge arriving in the gate cycle belongs to the interval being closed.
  assign w_sum       = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_sig_edge};
  assign w_sum_sat   = w_sum[CNT_W];
  assign w_latch_val = w_sum_sat ? CNT_MAX : w_sum[CNT_W-1:0];
  assign w_latch_ovf = r_ovf_int | w_sum_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '0;
      r_s_prev   <= 1'b0;
      r_cout_b_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_prev   <= w_s_sync;
      r_cout_b_d <= cout_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ovf_int <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf_int;
    w_latch      = 1'b0;
    if (!en) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_ARM;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
        end
        S_ARM: begin
          // The partial interval before the first gate is discarded.
          w_cnt_next = '0;
          w_ovf_next = 1'b0;
          if (w_gate) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (w_gate) begin
            w_latch    = 1'b1;
            w_cnt_next = '0;
            w_ovf_next = 1'b0;
          end else if (w_sig_edge) begin
            if (r_cnt == CNT_MAX) begin
              w_ovf_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
        end
      endcase
    end
  end

  // A latch always wins over rd_ack; an ack in the same cycle just marks the old data read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq_a     <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_missed     <= 1'b0;
    end else if (w_latch) begin
      r_freq_a     <= w_latch_val;
      r_overflow   <= w_latch_ovf;
      r_freq_valid <= 1'b1;
      if (r_freq_valid) begin
        r_missed <= ~rd_ack;
      end
    end else if (rd_ack && r_freq_valid) begin
      r_freq_valid <= 1'b0;
      r_missed     <= 1'b0;
    end
  end

  assign freq_a     = r_freq_a;
  assign freq_valid = r_freq_valid;
  assign overflow   = r_overflow;
  assign missed     = r_missed;

endmodule

// File: tb/tb_freq_a_gate_counter.sv
// Bench for freq_a_gate_counter: a 32-bit and a 4-bit instance share stimulus and
// are checked every cycle against an interval-level model with unbounded edge totals.
module tb_freq_a_gate_counter;

  localparam int SYNC = 2;
  localparam int WS   = 4;
  localparam longint MAX_M = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX_S = 64'd15;

  logic clk = 1'b0;
  logic reset, en, sig_in, cout_b, rd_ack;
  logic [31:0]   freq_m;
  logic [WS-1:0] freq_s;
  logic valid_m, ovf_m, missed_m;
  logic valid_s, ovf_s, missed_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  freq_a_gate_counter #(.CNT_W(32), .SYNC_STAGES(SYNC)) dut_m (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .cout_b(cout_b), .rd_ack(rd_ack),
    .freq_a(freq_m), .freq_valid(valid_m), .overflow(ovf_m), .missed(missed_m)
  );

  freq_a_gate_counter #(.CNT_W(WS), .SYNC_STAGES(SYNC)) dut_s (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .cout_b(cout_b), .rd_ack(rd_ack),
    .freq_a(freq_s), .freq_valid(valid_s), .overflow(ovf_s), .missed(missed_s)
  );

  // Model: phase 0 idle, 1 waiting for the arming gate, 2 counting.
  logic   hist [0:SYNC+1];
  logic   m_cbd = 1'b0;
  int     m_phase = 0;
  longint m_count = 0;
  longint m_freq [2];
  logic   m_ovf [2];
  logic   m_valid = 1'b0;
  logic   m_missed = 1'b0;
  logic   m_ready = 1'b0;

  initial begin
    for (int k = 0; k <= SYNC + 1; k++) hist[k] = 1'b0;
    m_freq[0] = 0; m_freq[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
  end

  always @(posedge clk) begin
    logic   e_sig, g_gate, latch;
    longint total, mx;
    for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = sig_in;
    // A sig_in rise is seen SYNC_STAGES+1 cycles after it is driven.
    e_sig  = hist[SYNC] && !hist[SYNC+1];
    g_gate = cout_b && !m_cbd;
    latch  = 1'b0;
    if (reset) begin
      m_phase = 0; m_count = 0; m_valid = 1'b0; m_missed = 1'b0;
      for (int i = 0; i < 2; i++) begin m_freq[i] = 0; m_ovf[i] = 1'b0; end
    end else begin
      if (!en) begin
        m_phase = 0; m_count = 0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_count = 0;
      end else if (m_phase == 1) begin
        if (g_gate) m_phase = 2;
        m_count = 0;
      end else if (g_gate) begin
        latch = 1'b1;
        total = m_count + (e_sig ? 1 : 0);
        for (int i = 0; i < 2; i++) begin
          mx = (i == 0) ? MAX_M : MAX_S;
          m_freq[i] = (total > mx) ? mx : total;
          m_ovf[i]  = (total > mx);
        end
        m_count = 0;
      end else if (e_sig) begin
        m_count = m_count + 1;
      end
      if (latch) begin
        if (m_valid) m_missed = !rd_ack;
        m_valid = 1'b1;
      end else if (rd_ack && m_valid) begin
        m_valid = 1'b0; m_missed = 1'b0;
      end
    end
    m_cbd = reset ? 1'b0 : cout_b;
    if (reset) for (int k = 0; k <= SYNC + 1; k++) hist[k] = 1'b0;
    m_ready = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Hand-computed expectations, applied both to the DUT and to the model.
  task automatic lit(input string name, input longint act, input longint model_v, input longint exp_v);
    chk({name, "_dut"}, act, exp_v);
    chk({name, "_model"}, model_v, exp_v);
    $display("[%0t] check %s: dut=%0d model=%0d expected=%0d", $time, name, act, model_v, exp_v);
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      chk("freq_a_32", longint'(freq_m), m_freq[0]);
      chk("valid_32", longint'(valid_m), longint'(m_valid));
      chk("ovf_32", longint'(ovf_m), longint'(m_ovf[0]));
      chk("missed_32", longint'(missed_m), longint'(m_missed));
      chk("freq_a_4", longint'(freq_s), m_freq[1]);
      chk("valid_4", longint'(valid_s), longint'(m_valid));
      chk("ovf_4", longint'(ovf_s), longint'(m_ovf[1]));
      chk("missed_4", longint'(missed_s), longint'(m_missed));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1; cyc(); cyc();
      sig_in = 1'b0; cyc(); cyc();
    end
    repeat (SYNC + 3) cyc();
  endtask

  task automatic gate_rise();
    cout_b = 1'b1;
    cyc();
  endtask

  task automatic gate_fall();
    cout_b = 1'b0;
    cyc();
  endtask

  task automatic ack();
    rd_ack = 1'b1; cyc();
    rd_ack = 1'b0; cyc();
  endtask

  initial begin
    int gcnt;
    reset = 1'b1; en = 1'b0; sig_in = 1'b0; cout_b = 1'b0; rd_ack = 1'b0;
    repeat (3) cyc();
    lit("reset_freq", longint'(freq_m), m_freq[0], 0);
    lit("reset_valid", longint'(valid_m), longint'(m_valid), 0);
    reset = 1'b0; en = 1'b1;

    // Nominal: gate every 1000 cycles, sig_in period 40.
    fork
      begin
        for (int k = 0; k < 2100; k++) begin
          if (k % 20 == 0) sig_in = ~sig_in;
          cyc();
        end
      end
      begin
        for (int k = 0; k < 2100; k++) begin
          cout_b = (k >= 10) && (((k - 10) % 1000) < 500);
          rd_ack = (k == 1020);
          cyc();
          if (k == 1010) begin
            lit("nominal_freq", longint'(freq_m), m_freq[0], 25);
            lit("nominal_valid", longint'(valid_m), longint'(m_valid), 1);
            lit("nominal_ovf", longint'(ovf_m), longint'(m_ovf[0]), 0);
            lit("nominal_missed", longint'(missed_m), longint'(m_missed), 0);
            lit("nominal_freq4", longint'(freq_s), m_freq[1], 15);
            lit("nominal_ovf4", longint'(ovf_s), longint'(m_ovf[1]), 1);
          end
          if (k == 1020) lit("nominal_ack_valid", longint'(valid_m), longint'(m_valid), 0);
        end
      end
    join
    sig_in = 1'b0; cout_b = 1'b0; rd_ack = 1'b0;
    repeat (8) cyc();
    ack();

    // Saturation on the 4-bit instance, then a small interval clears overflow.
    gate_rise(); gate_fall(); ack();
    pulses(20); gate_rise();
    lit("sat_freq32", longint'(freq_m), m_freq[0], 20);
    lit("sat_freq4", longint'(freq_s), m_freq[1], 15);
    lit("sat_ovf4", longint'(ovf_s), longint'(m_ovf[1]), 1);
    gate_fall(); ack();
    pulses(3); gate_rise();
    lit("post_sat_freq4", longint'(freq_s), m_freq[1], 3);
    lit("post_sat_ovf4", longint'(ovf_s), longint'(m_ovf[1]), 0);
    gate_fall(); ack();

    // Tenth edge lands exactly in the gate cycle.
    pulses(9);
    sig_in = 1'b1;
    repeat (SYNC) cyc();
    cout_b = 1'b1; cyc();
    lit("gate_edge_freq", longint'(freq_m), m_freq[0], 10);
    sig_in = 1'b0; cyc(); gate_fall(); ack();
    pulses(2); gate_rise();
    lit("after_gate_edge_freq", longint'(freq_m), m_freq[0], 2);
    gate_fall(); ack();

    // Missed read, then ack coinciding with a latch.
    pulses(5); gate_rise(); gate_fall();
    pulses(7); gate_rise();
    lit("missed_freq", longint'(freq_m), m_freq[0], 7);
    lit("missed_flag", longint'(missed_m), longint'(m_missed), 1);
    gate_fall();
    pulses(6);
    rd_ack = 1'b1; cout_b = 1'b1; cyc(); rd_ack = 1'b0;
    lit("simul_freq", longint'(freq_m), m_freq[0], 6);
    lit("simul_valid", longint'(valid_m), longint'(m_valid), 1);
    lit("simul_missed", longint'(missed_m), longint'(m_missed), 0);
    gate_fall(); ack();
    lit("ack_valid", longint'(valid_m), longint'(m_valid), 0);

    // Enable drop mid-interval; a gate while disabled is ignored.
    pulses(4); gate_rise(); gate_fall();
    pulses(2);
    en = 1'b0; cyc();
    gate_rise(); gate_fall(); repeat (5) cyc();
    lit("en_low_freq", longint'(freq_m), m_freq[0], 4);
    lit("en_low_valid", longint'(valid_m), longint'(m_valid), 1);
    en = 1'b1;
    pulses(3); gate_rise();
    lit("rearm_freq", longint'(freq_m), m_freq[0], 4);
    gate_fall();
    pulses(5); gate_rise();
    lit("reenable_freq", longint'(freq_m), m_freq[0], 5);
    gate_fall(); ack();

    // Reset mid-interval.
    pulses(3); gate_rise(); gate_fall();
    pulses(2);
    reset = 1'b1; cyc();
    lit("midreset_freq", longint'(freq_m), m_freq[0], 0);
    lit("midreset_valid", longint'(valid_m), longint'(m_valid), 0);
    reset = 1'b0; cyc();

    // Randomized traffic against the model.
    gcnt = 20;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) sig_in = ~sig_in;
      gcnt--;
      if (gcnt <= 0) begin
        cout_b = ~cout_b;
        gcnt = int'($urandom_range(5, 60));
      end
      rd_ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) en = ~en;
      if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      reset = ($urandom_range(0, 999) == 0);
      cyc();
    end
    reset = 1'b0; rd_ack = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
